id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and operand-forwarding front end for the execute stage. It captures decoded operands and control from ID, resolves RAW hazards by forwarding from MEM and WB, and presents `a`, `b` and `alucontrol` directly to the ALU. It also detects load-use hazards and inserts bubbles, and it honours stall and flush requests from the hazard/branch logic.

## Interface
- `WIDTH`, 32, datapath width
- `RBITS`, 5, register-index width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold all EX state (downstream back-pressure)
- `flush`  in  1  replace next EX content with a bubble (branch/jump redirect)
- `id_valid`  in  1  ID holds a real instruction
- `id_rd1`, `id_rd2`  in  WIDTH  register-file read data for rs, rt
- `id_imm`  in  WIDTH  extended immediate
- `id_rs`, `id_rt`, `id_dst`  in  RBITS  source indices and destination index
- `id_alusrc`  in  1  1 = ALU B takes the immediate
- `id_alucontrol`  in  3  ALU operation code
- `id_regwrite`, `id_memtoreg`, `id_memwrite`  in  1  control bits
- `mem_regwrite`  in  1  write enable of the instruction in MEM
- `mem_dst`  in  RBITS  destination of the instruction in MEM
- `mem_result`  in  WIDTH  result of the instruction in MEM
- `wb_regwrite`  in  1  write enable of the instruction in WB
- `wb_dst`  in  RBITS  destination of the instruction in WB
- `wb_result`  in  WIDTH  result of the instruction in WB
- `load_use`  out  1  combinational; upstream must hold PC and IF/ID this cycle
- `ex_valid`  out  1  EX holds a real instruction
- `alu_a`, `alu_b`  out  WIDTH  forwarded ALU operands
- `ex_alucontrol`  out  3  registered ALU operation code
- `ex_store_data`  out  WIDTH  forwarded rt value for stores
- `ex_dst`  out  RBITS  registered destination index
- `ex_regwrite`, `ex_memtoreg`, `ex_memwrite`  out  1  registered control bits, gated by `ex_valid`

## Operation
- **State.** The registered fields are valid, rd1, rd2, imm, rs, rt, dst, alusrc, alucontrol, regwrite, memtoreg and memwrite.
- **`load_use`.** Asserted when all of the following hold: `ex_valid`, `ex_memtoreg`, `ex_dst != 0`, `id_valid`, and `ex_dst` equals either `id_rs`, or `id_rt` with `!id_alusrc || id_memwrite`.
- **Update priority at each edge (highest first):**
  - `flush`: load a bubble. This overrides `stall`.
  - `stall`: hold every field.
  - `load_use`: load a bubble.
  - Otherwise: load every ID field, with valid = `id_valid`.
- **Bubble.** All fields cleared to 0, including valid and all control bits.
- **Forwarding, per operand (rs for A, rt for B/store), combinational from registered indices:**
  - If `mem_regwrite` and `mem_dst == idx` and `idx != 0`, take `mem_result`.
  - Else if `wb_regwrite` and `wb_dst == idx` and `idx != 0`, take `wb_result`.
  - Else take the registered rd1/rd2.
  - MEM has priority over WB.
- **Operand outputs.**
  - `alu_a` = forwarded rs.
  - `ex_store_data` = forwarded rt.
  - `alu_b` = registered alusrc ? imm : forwarded rt.
- **Control outputs.** `ex_regwrite`, `ex_memtoreg` and `ex_memwrite` are the registered bits ANDed with `ex_valid`.
- **Register 0.** Index 0 is never forwarded; the registered rd value (0 from the register file) is used.
- **During `stall`.** Forwarding keeps evaluating against live MEM/WB inputs. The stalling logic must keep those stages frozen.

## Timing
- **Reset.** `rst_n` low clears all state immediately (asynchronously), regardless of `clk`. This applies mid-operation as well. With all state cleared:
  - `ex_valid`, `ex_alucontrol`, `ex_dst` and all control outputs are 0.
  - `alu_a` and `ex_store_data` equal the forwarded value of index 0, which is 0.
  - `alu_b` is 0.
- **Latency.** ID inputs sampled at edge N appear on the EX outputs after edge N.
- **Combinational paths.**
  - MEM/WB inputs to `alu_a`/`alu_b`: zero-cycle.
  - `load_use` depends on ID inputs and registered state, with no registered delay.
- **Load-use.** A load-use hazard costs exactly one bubble. On the following cycle the load is in MEM, `load_use` deasserts and the dependent instruction loads. Its rs/rt are then served from MEM or WB through forwarding.
- **Simultaneous `flush` and `load_use`.** A bubble is loaded; `load_use` is still asserted, which is harmless.
- **Simultaneous `stall` and `load_use`.** The register holds. `load_use` is re-evaluated on the next cycle.

## Test plan
- **Reset mid-stream.** Run ADDs, then pull `rst_n` low between edges. Required: `ex_valid`, `ex_regwrite`, `alu_a` and `alu_b` go to 0 before the next edge, and stay 0 until the first edge after release.
- **Forward priority.**
  - Stimulus: EX rs = 8; `mem_dst` = 8, `mem_result` = 0x11; `wb_dst` = 8, `wb_result` = 0x22; registered rd1 = 0x33. Required: `alu_a` = 0x11.
  - Drop `mem_regwrite`. Required: `alu_a` = 0x22.
  - Drop `wb_regwrite` as well. Required: `alu_a` = 0x33.
- **Zero register.** Stimulus: rs = 0, `mem_dst` = 0, `mem_regwrite` = 1, `mem_result` = 0xFFFF_FFFF. Required: `alu_a` = 0.
- **Load-use.**
  - Stimulus: LW to $9 in EX, then ID holds ADD with rs = 9. Required: `load_use` = 1, and `ex_valid` = 0 on the next cycle.
  - Then, with `mem_result` = 0x55 for $9. Required: ADD loads and `alu_a` = 0x55.
  - Also check with ID holding ADDI, rt = 9, `alusrc` = 1. Required: `load_use` = 0.
- **Immediate and store.** Stimulus: SW with `alusrc` = 1, imm = 4, rt = 5, and WB forwarding 0xABCD to $5. Required: `alu_b` = 4, `ex_store_data` = 0xABCD, `ex_memwrite` = 1.
- **Stall/flush priority.** Assert `stall` for 2 cycles while ID changes. Required: outputs unchanged. Assert `stall` and `flush` together. Required: bubble with `ex_valid` = 0 and `ex_regwrite` = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Presents forwarded ALU operands and gated control bits to the execute stage.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RBITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic [RBITS-1:0] id_dst,
  input  logic             id_alusrc,
  input  logic [2:0]       id_alucontrol,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             mem_regwrite,
  input  logic [RBITS-1:0] mem_dst,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_regwrite,
  input  logic [RBITS-1:0] wb_dst,
  input  logic [WIDTH-1:0] wb_result,
  output logic             load_use,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       ex_alucontrol,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RBITS-1:0] ex_dst,
  output logic             ex_regwrite,
  output logic             ex_memtoreg,
  output logic             ex_memwrite
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RBITS-1:0] rs;
    logic [RBITS-1:0] rt;
    logic [RBITS-1:0] dst;
    logic             alusrc;
    logic [2:0]       alucontrol;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
  } ex_t;

  ex_t              ex_q;
  ex_t              ex_d;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  // A load in EX whose destination is consumed by the instruction in ID
  assign load_use = ex_q.valid && ex_q.memtoreg && (ex_q.dst != '0) && id_valid &&
                    ((ex_q.dst == id_rs) ||
                     ((ex_q.dst == id_rt) && (!id_alusrc || id_memwrite)));

  // Update priority: flush, stall, load-use bubble, then load from ID
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.rd1        = id_rd1;
      ex_d.rd2        = id_rd2;
      ex_d.imm        = id_imm;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dst        = id_dst;
      ex_d.alusrc     = id_alusrc;
      ex_d.alucontrol = id_alucontrol;
      ex_d.regwrite   = id_regwrite;
      ex_d.memtoreg   = id_memtoreg;
      ex_d.memwrite   = id_memwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // MEM has priority over WB; register 0 is never forwarded
  always_comb begin
    fwd_a = ex_q.rd1;
    if (mem_regwrite && (mem_dst == ex_q.rs) && (ex_q.rs != '0)) begin
      fwd_a = mem_result;
    end else if (wb_regwrite && (wb_dst == ex_q.rs) && (ex_q.rs != '0)) begin
      fwd_a = wb_result;
    end
  end

  always_comb begin
    fwd_b = ex_q.rd2;
    if (mem_regwrite && (mem_dst == ex_q.rt) && (ex_q.rt != '0)) begin
      fwd_b = mem_result;
    end else if (wb_regwrite && (wb_dst == ex_q.rt) && (ex_q.rt != '0)) begin
      fwd_b = wb_result;
    end
  end

  assign alu_a         = fwd_a;
  assign alu_b         = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_valid      = ex_q.valid;
  assign ex_alucontrol = ex_q.alucontrol;
  assign ex_dst        = ex_q.dst;
  assign ex_regwrite   = ex_q.regwrite & ex_q.valid;
  assign ex_memtoreg   = ex_q.memtoreg & ex_q.valid;
  assign ex_memwrite   = ex_q.memwrite & ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a model of "the instruction held in EX" predicts every output.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        alusrc;
    logic [2:0]  aluc;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
  } instr_t;

  typedef struct {
    logic        load_use;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [2:0]  aluc;
    logic [4:0]  dst;
    logic        rw;
    logic        mtr;
    logic        mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  instr_t      id;
  logic        mem_rw;
  logic [4:0]  mem_dst;
  logic [31:0] mem_res;
  logic        wb_rw;
  logic [4:0]  wb_dst;
  logic [31:0] wb_res;

  logic        load_use;
  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  ex_alucontrol;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dst;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic        ex_memwrite;

  int     checks;
  int     errors;
  exp_t   q[$];
  instr_t ex_m;
  instr_t x;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .RBITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id.valid), .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm),
    .id_rs(id.rs), .id_rt(id.rt), .id_dst(id.dst), .id_alusrc(id.alusrc),
    .id_alucontrol(id.aluc), .id_regwrite(id.regwrite), .id_memtoreg(id.memtoreg),
    .id_memwrite(id.memwrite),
    .mem_regwrite(mem_rw), .mem_dst(mem_dst), .mem_result(mem_res),
    .wb_regwrite(wb_rw), .wb_dst(wb_dst), .wb_result(wb_res),
    .load_use(load_use), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .ex_alucontrol(ex_alucontrol), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite)
  );

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                                input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                                input logic alusrc, input logic rw, input logic mtr, input logic mw);
    instr_t i;
    i.valid = 1'b1; i.rs = rs; i.rt = rt; i.dst = dst;
    i.rd1 = rd1; i.rd2 = rd2; i.imm = imm; i.alusrc = alusrc;
    i.aluc = 3'($urandom_range(0, 7));
    i.regwrite = rw; i.memtoreg = mtr; i.memwrite = mw;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid = ($urandom_range(0, 9) < 8);
    i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom;
    i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3));
    i.dst = 5'($urandom_range(0, 3));
    i.alusrc = 1'($urandom_range(0, 1)); i.aluc = 3'($urandom_range(0, 7));
    i.regwrite = 1'($urandom_range(0, 1)); i.memtoreg = 1'($urandom_range(0, 1));
    i.memwrite = 1'($urandom_range(0, 1));
    return i;
  endfunction

  // A load in EX stalls an ID instruction that reads its destination
  function automatic logic hazard(input instr_t e, input instr_t d);
    logic reads_rt;
    reads_rt = !d.alusrc || d.memwrite;
    return e.valid && e.memtoreg && (e.dst != 0) && d.valid &&
           ((e.dst == d.rs) || (reads_rt && (e.dst == d.rt)));
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regval);
    if (idx == 0) return regval;
    if (mem_rw && mem_dst == idx) return mem_res;
    if (wb_rw && wb_dst == idx) return wb_res;
    return regval;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id = bubble(); stall = 1'b0; flush = 1'b0;
    mem_rw = 1'b0; mem_dst = '0; mem_res = '0;
    wb_rw = 1'b0; wb_dst = '0; wb_res = '0;
  endtask

  // Advance one edge: the model applies the inputs the DUT just sampled
  task automatic step();
    @(posedge clk);
    if (flush) ex_m = bubble();
    else if (stall) ex_m = ex_m;
    else if (hazard(ex_m, id)) ex_m = bubble();
    else ex_m = id;
    #1;
  endtask

  task automatic push();
    exp_t e;
    logic [31:0] fb;
    fb = fwd(ex_m.rt, ex_m.rd2);
    e.load_use = hazard(ex_m, id);
    e.valid = ex_m.valid;
    e.a = fwd(ex_m.rs, ex_m.rd1);
    e.b = ex_m.alusrc ? ex_m.imm : fb;
    e.sd = fb;
    e.aluc = ex_m.aluc;
    e.dst = ex_m.dst;
    e.rw = ex_m.valid && ex_m.regwrite;
    e.mtr = ex_m.valid && ex_m.memtoreg;
    e.mw = ex_m.valid && ex_m.memwrite;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_load_use", 32'(load_use), 32'(e.load_use));
        chk("sb_valid", 32'(ex_valid), 32'(e.valid));
        chk("sb_alu_a", alu_a, e.a);
        chk("sb_alu_b", alu_b, e.b);
        chk("sb_store", ex_store_data, e.sd);
        chk("sb_aluc", 32'(ex_alucontrol), 32'(e.aluc));
        chk("sb_dst", 32'(ex_dst), 32'(e.dst));
        chk("sb_regwrite", 32'(ex_regwrite), 32'(e.rw));
        chk("sb_memtoreg", 32'(ex_memtoreg), 32'(e.mtr));
        chk("sb_memwrite", 32'(ex_memwrite), 32'(e.mw));
      end
    end
  end

  initial begin : driver
    checks = 0; errors = 0;
    rst_n = 1'b0;
    idle();
    ex_m = bubble();
    mem_rw = 1'b1; mem_dst = '0; mem_res = 32'hFFFF_FFFF;
    #2;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_regwrite", 32'(ex_regwrite), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Forwarding priority MEM > WB > register file
    step(); idle(); id = mk(8, 2, 10, 32'h33, 32'h44, 0, 1'b0, 1'b1, 1'b0, 1'b0); push();
    step(); idle(); stall = 1'b1;
    mem_rw = 1'b1; mem_dst = 8; mem_res = 32'h11; wb_rw = 1'b1; wb_dst = 8; wb_res = 32'h22;
    push(); #1 chk("fwd_mem", alu_a, 32'h11);
    step(); mem_rw = 1'b0; push(); #1 chk("fwd_wb", alu_a, 32'h22);
    step(); wb_rw = 1'b0; push(); #1 chk("fwd_reg", alu_a, 32'h33);

    // Register 0 is never forwarded
    step(); idle(); id = mk(0, 0, 1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0); push();
    step(); idle(); mem_rw = 1'b1; mem_dst = 0; mem_res = 32'hFFFF_FFFF; push();
    #1 chk("zero_reg", alu_a, 0);

    // Load-use: one bubble, then forward the loaded value
    step(); idle(); id = mk(1, 9, 9, 32'h100, 0, 8, 1'b1, 1'b1, 1'b1, 1'b0); push();
    step(); idle(); id = mk(9, 2, 3, 32'h7, 32'h8, 0, 1'b0, 1'b1, 1'b0, 1'b0); push();
    #1 chk("lu_assert", 32'(load_use), 1);
    step(); mem_rw = 1'b1; mem_dst = 9; mem_res = 32'h55; push();
    #1 chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_release", 32'(load_use), 0);
    step(); id = bubble(); push();
    #1 chk("lu_fwd", alu_a, 32'h55);
    chk("lu_loaded", 32'(ex_valid), 1);
    step(); idle(); id = mk(1, 9, 9, 32'h100, 0, 8, 1'b1, 1'b1, 1'b1, 1'b0); push();
    step(); idle(); id = mk(3, 9, 4, 32'h1, 32'h2, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0); push();
    #1 chk("lu_addi", 32'(load_use), 0);

    // Store: immediate on B, forwarded rt as store data
    step(); idle(); id = mk(6, 5, 0, 32'h60, 32'h1111, 4, 1'b1, 1'b0, 1'b0, 1'b1); push();
    step(); idle(); wb_rw = 1'b1; wb_dst = 5; wb_res = 32'hABCD; push();
    #1 chk("sw_alu_b", alu_b, 4);
    chk("sw_store", ex_store_data, 32'hABCD);
    chk("sw_memwrite", 32'(ex_memwrite), 1);

    // Stall holds for two edges, then flush beats stall
    x = mk(6, 7, 12, 32'hCAFE_0001, 32'hCAFE_0002, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); idle(); id = x; push();
    step(); idle(); stall = 1'b1; id = rand_instr(); push();
    step(); stall = 1'b1; id = rand_instr(); push();
    step(); stall = 1'b1; flush = 1'b1; id = rand_instr(); push();
    #1 chk("stall_a", alu_a, x.rd1);
    chk("stall_b", alu_b, x.rd2);
    chk("stall_dst", 32'(ex_dst), 32'(x.dst));
    step(); idle(); push();
    #1 chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_regwrite", 32'(ex_regwrite), 0);

    // Reset mid-stream clears state asynchronously
    repeat (3) begin
      step(); idle(); id = mk(1, 2, 3, $urandom, $urandom, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      mem_rw = 1'b1; mem_dst = 1; mem_res = 32'h1234_5678; push();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mrst_valid", 32'(ex_valid), 0);
    chk("mrst_regwrite", 32'(ex_regwrite), 0);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_b", alu_b, 0);
    @(posedge clk);
    #1 chk("mrst_hold_valid", 32'(ex_valid), 0);
    chk("mrst_hold_a", alu_a, 0);
    rst_n = 1'b1;
    #1 chk("mrst_rel_valid", 32'(ex_valid), 0);
    chk("mrst_rel_b", alu_b, 0);
    ex_m = bubble();

    // Randomized traffic with narrow indices to provoke hazards and forwarding
    repeat (3000) begin
      step();
      id = rand_instr();
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      mem_rw = 1'($urandom_range(0, 1)); mem_dst = 5'($urandom_range(0, 3)); mem_res = $urandom;
      wb_rw = 1'($urandom_range(0, 1)); wb_dst = 5'($urandom_range(0, 3)); wb_res = $urandom;
      push();
    end

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
